// File: rtl/wb_mux_n.sv
// N-way Wishbone interconnect: decodes the top SEL_BITS of the CPU address and routes one cycle
// to the selected slave. Optional stuck-slave timeout: define WB_MUX_TIMEOUT_EN.
module wb_mux_n #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_BITS   = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_wb_cpu_adr,
    input  logic [31:0]              i_wb_cpu_dat,
    input  logic [3:0]               i_wb_cpu_sel,
    input  logic                     i_wb_cpu_we,
    input  logic                     i_wb_cpu_cyc,
    output logic [31:0]              o_wb_cpu_rdt,
    output logic                     o_wb_cpu_ack,
    output logic                     o_wb_cpu_err,
    output logic [31:0]              o_wb_s_adr,
    output logic [31:0]              o_wb_s_dat,
    output logic [3:0]               o_wb_s_sel,
    output logic                     o_wb_s_we,
    output logic [NUM_SLAVES-1:0]    o_wb_s_cyc,
    input  logic [NUM_SLAVES*32-1:0] i_wb_s_rdt,
    input  logic [NUM_SLAVES-1:0]    i_wb_s_ack,
    output logic                     o_busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state;
    logic [SEL_BITS-1:0] sel_idx;
    logic [SEL_BITS-1:0] sel_q;
    logic                sel_ack;
    logic [31:0]         sel_rdt;

`ifdef WB_MUX_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;
`endif

    assign o_wb_s_adr = i_wb_cpu_adr;
    assign o_wb_s_dat = i_wb_cpu_dat;
    assign o_wb_s_sel = i_wb_cpu_sel;
    assign o_wb_s_we  = i_wb_cpu_we;
    assign sel_idx    = i_wb_cpu_adr[31 -: SEL_BITS];
    assign o_busy     = (state != StIdle);

    // Routing follows the latched index, never the live address.
    always_comb begin
        sel_ack = 1'b0;
        sel_rdt = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_BITS'(i)) begin
                sel_ack = i_wb_s_ack[i];
                sel_rdt = i_wb_s_rdt[32*i +: 32];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= StIdle;
            sel_q        <= '0;
            o_wb_s_cyc   <= '0;
            o_wb_cpu_ack <= 1'b0;
            o_wb_cpu_err <= 1'b0;
            o_wb_cpu_rdt <= '0;
`ifdef WB_MUX_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    o_wb_cpu_ack <= 1'b0;
                    o_wb_cpu_err <= 1'b0;
                    if (i_wb_cpu_cyc) begin
                        sel_q <= sel_idx;
                        if (32'(sel_idx) < NUM_SLAVES) begin
                            state      <= StBusy;
                            o_wb_s_cyc <= NUM_SLAVES'(1) << sel_idx;
`ifdef WB_MUX_TIMEOUT_EN
                            tmo_cnt    <= '0;
`endif
                        end else begin
                            // Unmapped: answer directly with an error, no slave involved.
                            state        <= StResp;
                            o_wb_cpu_ack <= 1'b1;
                            o_wb_cpu_err <= 1'b1;
                            o_wb_cpu_rdt <= '0;
                        end
                    end
                end
                StBusy: begin
                    if (sel_ack) begin
                        state        <= StResp;
                        o_wb_s_cyc   <= '0;
                        o_wb_cpu_rdt <= sel_rdt;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_err <= 1'b0;
                    end else if (!i_wb_cpu_cyc) begin
                        state      <= StIdle;
                        o_wb_s_cyc <= '0;
                    end
`ifdef WB_MUX_TIMEOUT_EN
                    else if (tmo_cnt == TmoLast) begin
                        state        <= StResp;
                        o_wb_s_cyc   <= '0;
                        o_wb_cpu_rdt <= '0;
                        o_wb_cpu_ack <= 1'b1;
                        o_wb_cpu_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                StResp: begin
                    state        <= StIdle;
                    o_wb_cpu_ack <= 1'b0;
                    o_wb_cpu_err <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mux_n.sv
// Directed bench for wb_mux_n: a 4-slave instance and a 3-slave instance (TIMEOUT=8) share the
// CPU-side address/data; each has its own cyc and slave-side signals.
module tb_wb_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc_a, cyc_b;

    logic [31:0]  rdt_a, s_adr_a, s_dat_a;
    logic         ack_a, err_a, s_we_a, busy_a;
    logic [3:0]   s_sel_a, s_cyc_a, s_ack_a;
    logic [127:0] s_rdt_a;

    logic [31:0]  rdt_b, s_adr_b, s_dat_b;
    logic         ack_b, err_b, s_we_b, busy_b;
    logic [3:0]   s_sel_b;
    logic [2:0]   s_cyc_b, s_ack_b;
    logic [95:0]  s_rdt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_mux_n dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel), .i_wb_cpu_we(we),
        .i_wb_cpu_cyc(cyc_a), .o_wb_cpu_rdt(rdt_a), .o_wb_cpu_ack(ack_a), .o_wb_cpu_err(err_a),
        .o_wb_s_adr(s_adr_a), .o_wb_s_dat(s_dat_a), .o_wb_s_sel(s_sel_a), .o_wb_s_we(s_we_a),
        .o_wb_s_cyc(s_cyc_a), .i_wb_s_rdt(s_rdt_a), .i_wb_s_ack(s_ack_a), .o_busy(busy_a)
    );

    wb_mux_n #(.NUM_SLAVES(3), .SEL_BITS(2), .TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel), .i_wb_cpu_we(we),
        .i_wb_cpu_cyc(cyc_b), .o_wb_cpu_rdt(rdt_b), .o_wb_cpu_ack(ack_b), .o_wb_cpu_err(err_b),
        .o_wb_s_adr(s_adr_b), .o_wb_s_dat(s_dat_b), .o_wb_s_sel(s_sel_b), .o_wb_s_we(s_we_b),
        .o_wb_s_cyc(s_cyc_b), .i_wb_s_rdt(s_rdt_b), .i_wb_s_ack(s_ack_b), .o_busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; adr = '0; dat = '0; sel = 4'hF; we = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
        s_ack_a = '0; s_ack_b = '0;
        s_rdt_a = {32'h3333_CAFE, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        s_rdt_b = {32'hA5A5_0F0F, 32'h0B0B_0B0B, 32'h7777_0001};
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_scyc_a", 32'(s_cyc_a), 32'h0);
        check("rst_ack_a", 32'(ack_a), 32'h0);
        check("rst_err_a", 32'(err_a), 32'h0);
        check("rst_rdt_a", rdt_a, 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_scyc_b", 32'(s_cyc_b), 32'h0);

        // Read slave 1, immediate ack
        adr = 32'h4000_0010; we = 1'b0; cyc_a = 1'b1; s_ack_a = 4'b0010;
        tick();
        check("rd1_scyc", 32'(s_cyc_a), 32'h2);
        check("rd1_noack_early", 32'(ack_a), 32'h0);
        check("rd1_busy", 32'(busy_a), 32'h1);
        tick();
        check("rd1_ack", 32'(ack_a), 32'h1);
        check("rd1_err", 32'(err_a), 32'h0);
        check("rd1_rdt", rdt_a, 32'hDEAD_BEEF);
        check("rd1_scyc_clr", 32'(s_cyc_a), 32'h0);
        cyc_a = 1'b0; s_ack_a = '0;
        tick();
        check("rd1_ack_single", 32'(ack_a), 32'h0);
        check("rd1_idle", 32'(busy_a), 32'h0);

        // Reset while BUSY on slave 1
        adr = 32'h4000_0000; cyc_a = 1'b1;
        tick();
        check("rstb_scyc", 32'(s_cyc_a), 32'h2);
        rst = 1'b1; cyc_a = 1'b0;
        tick();
        rst = 1'b0;
        check("rstb_scyc_clr", 32'(s_cyc_a), 32'h0);
        check("rstb_busy", 32'(busy_a), 32'h0);
        check("rstb_ack", 32'(ack_a), 32'h0);
        check("rstb_rdt", rdt_a, 32'h0);
        tick();
        check("rstb_ack_after", 32'(ack_a), 32'h0);

        // Write slave 3, ack after 5 wait states; stray acks and an address change meanwhile
        adr = 32'hC000_0000; dat = 32'h1234_5678; we = 1'b1; sel = 4'h5; cyc_a = 1'b1;
        s_ack_a = 4'b0011;
        tick();
        for (int k = 1; k <= 6; k++) begin
            check("wr3_scyc", 32'(s_cyc_a), 32'h8);
            check("wr3_noack", 32'(ack_a), 32'h0);
            check("wr3_sdat", s_dat_a, 32'h1234_5678);
            check("wr3_sadr", s_adr_a, adr);
            check("wr3_swe", 32'(s_we_a), 32'h1);
            check("wr3_ssel", 32'(s_sel_a), 32'h5);
            if (k == 3) adr = 32'h4000_0000;
            if (k == 6) s_ack_a = 4'b1000;
            tick();
        end
        check("wr3_ack", 32'(ack_a), 32'h1);
        check("wr3_err", 32'(err_a), 32'h0);
        check("wr3_rdt", rdt_a, 32'h3333_CAFE);
        check("wr3_scyc_clr", 32'(s_cyc_a), 32'h0);
        cyc_a = 1'b0; s_ack_a = '0; we = 1'b0; sel = 4'hF;
        tick();
        check("wr3_ack_single", 32'(ack_a), 32'h0);

        // Back-to-back: cyc left high after ack starts a new transaction
        adr = 32'h0000_0008; cyc_a = 1'b1; s_ack_a = 4'b0001;
        tick();
        check("b2b_scyc", 32'(s_cyc_a), 32'h1);
        tick();
        check("b2b_ack", 32'(ack_a), 32'h1);
        check("b2b_rdt", rdt_a, 32'h0000_1111);
        s_ack_a = '0;
        tick();
        check("b2b_idle_ack", 32'(ack_a), 32'h0);
        check("b2b_idle_busy", 32'(busy_a), 32'h0);
        tick();
        check("b2b_again_scyc", 32'(s_cyc_a), 32'h1);
        check("b2b_again_ack", 32'(ack_a), 32'h0);

        // CPU abort during BUSY, then a stray slave ack
        cyc_a = 1'b0;
        tick();
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_scyc", 32'(s_cyc_a), 32'h0);
        check("abort_ack", 32'(ack_a), 32'h0);
        s_ack_a = 4'b0001;
        tick();
        check("stray_ack", 32'(ack_a), 32'h0);
        check("stray_busy", 32'(busy_a), 32'h0);
        s_ack_a = '0;

        // 3-slave instance: mapped read of slave 2, then an unmapped access
        adr = 32'h8000_0000; cyc_b = 1'b1; s_ack_b = 3'b100;
        tick();
        check("b_rd2_scyc", 32'(s_cyc_b), 32'h4);
        tick();
        check("b_rd2_ack", 32'(ack_b), 32'h1);
        check("b_rd2_rdt", rdt_b, 32'hA5A5_0F0F);
        cyc_b = 1'b0; s_ack_b = '0;
        tick();
        adr = 32'hC000_0000; cyc_b = 1'b1;
        tick();
        check("unmap_scyc", 32'(s_cyc_b), 32'h0);
        check("unmap_ack", 32'(ack_b), 32'h1);
        check("unmap_err", 32'(err_b), 32'h1);
        check("unmap_rdt", rdt_b, 32'h0);
        cyc_b = 1'b0;
        tick();
        check("unmap_ack_single", 32'(ack_b), 32'h0);
        check("unmap_err_clr", 32'(err_b), 32'h0);

`ifdef WB_MUX_TIMEOUT_EN
        // Ack in the 8th BUSY cycle wins over the timeout
        adr = 32'h0000_0004; cyc_b = 1'b1; s_ack_b = '0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            check("tmo_ack8_scyc", 32'(s_cyc_b), 32'h1);
            check("tmo_ack8_noack", 32'(ack_b), 32'h0);
            if (k == 8) s_ack_b = 3'b001;
            tick();
        end
        check("tmo_ack8_ack", 32'(ack_b), 32'h1);
        check("tmo_ack8_err", 32'(err_b), 32'h0);
        check("tmo_ack8_rdt", rdt_b, 32'h7777_0001);
        cyc_b = 1'b0; s_ack_b = '0;
        tick();
        // Slave 0 never acks: error after exactly 8 BUSY cycles
        cyc_b = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            check("tmo_scyc", 32'(s_cyc_b), 32'h1);
            check("tmo_noack", 32'(ack_b), 32'h0);
            tick();
        end
        check("tmo_ack", 32'(ack_b), 32'h1);
        check("tmo_err", 32'(err_b), 32'h1);
        check("tmo_rdt", rdt_b, 32'h0);
        check("tmo_scyc_clr", 32'(s_cyc_b), 32'h0);
        cyc_b = 1'b0;
        tick();
        check("tmo_ack_single", 32'(ack_b), 32'h0);
`else
        // Without the timeout a silent slave simply holds the bus until the CPU aborts
        adr = 32'h0000_0004; cyc_b = 1'b1; s_ack_b = '0;
        tick();
        for (int k = 1; k <= 20; k++) begin
            check("wait_scyc", 32'(s_cyc_b), 32'h1);
            check("wait_noack", 32'(ack_b), 32'h0);
            check("wait_noerr", 32'(err_b), 32'h0);
            tick();
        end
        cyc_b = 1'b0;
        tick();
        check("wait_abort_busy", 32'(busy_b), 32'h0);
        check("wait_abort_scyc", 32'(s_cyc_b), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
